// File: rtl/pong_pkg.sv
// Shared constants for the Pong datapath: clock rate and the default
// ball/paddle speed settings.
package pong_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;

    // Number of clk cycles between motion steps for a given step rate.
    function automatic int unsigned period_for_hz(input int unsigned hz);
        return CLK_HZ / hz;
    endfunction

    localparam int unsigned DEF_CNT_W       = 24;
    localparam int unsigned DEF_LEVEL_W     = 4;
    localparam int unsigned DEF_INIT_PERIOD = period_for_hz(160);  // 312500
    localparam int unsigned DEF_STEP        = 30_000;
    localparam int unsigned DEF_MIN_PERIOD  = 62_500;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector. The history bit clears on reset, so an
// input that is already high when reset releases counts as one edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic evt
);

    logic din_d;

    // One-cycle history of the input, tracked every cycle.
    always_ff @(posedge clk) begin
        if (rst) din_d <= 1'b0;
        else     din_d <= din;
    end

    assign evt = din & ~din_d;

endmodule

// File: rtl/ball_speed_ctrl.sv
// Ball-motion tick generator. A down-to-floor period register sets the spacing
// of one-cycle ticks; collisions shorten the period, a score restores the
// serve speed, and en=0 freezes the counter without losing phase.
module ball_speed_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned INIT_PERIOD = DEF_INIT_PERIOD,
    parameter int unsigned STEP        = DEF_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned LEVEL_W     = DEF_LEVEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               collision,
    input  logic               score,
    output logic               tick,
    output logic [CNT_W-1:0]   period,
    output logic [LEVEL_W-1:0] level,
    output logic               at_max
);

    if (MIN_PERIOD < 2) begin : g_bad_min
        $error("ball_speed_ctrl: MIN_PERIOD must be at least 2");
    end
    if (INIT_PERIOD < MIN_PERIOD) begin : g_bad_init
        $error("ball_speed_ctrl: INIT_PERIOD must not be below MIN_PERIOD");
    end
    if (STEP < 1) begin : g_bad_step
        $error("ball_speed_ctrl: STEP must be at least 1");
    end
    if (64'(INIT_PERIOD) >= (64'd1 << CNT_W)) begin : g_bad_width
        $error("ball_speed_ctrl: INIT_PERIOD does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0]   INIT_P    = CNT_W'(INIT_PERIOD);
    localparam logic [CNT_W-1:0]   MIN_P     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]   STEP_P    = CNT_W'(STEP);
    // One bit wider so MIN+STEP never wraps for large parameter choices.
    localparam logic [CNT_W:0]     SHRINK_LO = (CNT_W+1)'(MIN_PERIOD) + (CNT_W+1)'(STEP);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
    localparam logic               AT_MAX_RST = (INIT_PERIOD == MIN_PERIOD);

    logic               col_evt;
    logic               scr_evt;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   period_nxt;
    logic [LEVEL_W-1:0] level_nxt;
    logic [LEVEL_W-1:0] level_inc;

    rise_detect u_col_edge (
        .clk (clk),
        .rst (rst),
        .din (collision),
        .evt (col_evt)
    );

    rise_detect u_scr_edge (
        .clk (clk),
        .rst (rst),
        .din (score),
        .evt (scr_evt)
    );

    assign level_inc = (level == LEVEL_MAX) ? level : level + 1'b1;

    // Next period/level: score wins over collision; shrink is guarded so the
    // subtraction cannot go below the floor.
    always_comb begin
        period_nxt = period;
        level_nxt  = level;
        if (scr_evt) begin
            period_nxt = INIT_P;
            level_nxt  = '0;
        end else if (col_evt) begin
            if ({1'b0, period} >= SHRINK_LO) begin
                period_nxt = period - STEP_P;
                level_nxt  = level_inc;
            end else begin
                period_nxt = MIN_P;
                if (period != MIN_P) level_nxt = level_inc;
            end
        end
    end

    // Period, level and at_max registers; at_max tracks the value being loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            period <= INIT_P;
            level  <= '0;
            at_max <= AT_MAX_RST;
        end else begin
            period <= period_nxt;
            level  <= level_nxt;
            at_max <= (period_nxt == MIN_P);
        end
    end

    // Tick counter; the >= compare forces a wrap if the period shrank below count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (count >= period - CNT_W'(1)) begin
                count <= '0;
                tick  <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule
